// File: rtl/tpu_stride_agu.sv
// Multi-channel strided address generator: each channel walks base + k*stride for len beats,
// and all channels share one registered beat slot through a round-robin arbiter.
module tpu_stride_agu #(
    parameter int NUM_CH     = 2,
    parameter int WIDTH_ADDR = 10,
    parameter int WIDTH_CH   = ($clog2(NUM_CH) > 0) ? $clog2(NUM_CH) : 1
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [NUM_CH-1:0]            I_Req,
    input  logic [NUM_CH*WIDTH_ADDR-1:0] I_Base,
    input  logic [NUM_CH*WIDTH_ADDR-1:0] I_Stride,
    input  logic [NUM_CH*WIDTH_ADDR-1:0] I_Len,
    input  logic [NUM_CH-1:0]            I_Abort,
    output logic [NUM_CH-1:0]            O_Busy,
    output logic                         O_Req,
    output logic [WIDTH_ADDR-1:0]        O_Addr,
    output logic [WIDTH_CH-1:0]          O_Ch,
    output logic                         O_Last,
    input  logic                         I_Ack,
    output logic [NUM_CH-1:0]            O_Done
);

    // DRAIN: aborted, but a beat of this channel still sits in the slot awaiting its ack.
    typedef enum logic [1:0] {
        CH_IDLE,
        CH_RUN,
        CH_DRAIN
    } ch_state_e;

    ch_state_e             state_q  [NUM_CH];
    ch_state_e             state_d  [NUM_CH];
    logic [WIDTH_ADDR-1:0] addr_q   [NUM_CH];
    logic [WIDTH_ADDR-1:0] addr_d   [NUM_CH];
    logic [WIDTH_ADDR-1:0] stride_q [NUM_CH];
    logic [WIDTH_ADDR-1:0] stride_d [NUM_CH];
    logic [WIDTH_ADDR-1:0] rem_q    [NUM_CH];
    logic [WIDTH_ADDR-1:0] rem_d    [NUM_CH];
    logic [NUM_CH-1:0]     done_q, done_d;
    logic [WIDTH_CH-1:0]   rr_ptr_q, rr_ptr_d;

    logic                  out_req_q, out_req_d;
    logic [WIDTH_ADDR-1:0] out_addr_q, out_addr_d;
    logic [WIDTH_CH-1:0]   out_ch_q, out_ch_d;
    logic                  out_last_q, out_last_d;

    logic                  slot_free;
    logic [NUM_CH-1:0]     eligible;
    logic [NUM_CH-1:0]     slot_keeps;
    logic                  grant_valid;
    logic [WIDTH_CH-1:0]   grant;
    logic [WIDTH_CH-1:0]   sel;

    always_comb begin
        slot_free = !out_req_q || I_Ack;
        for (int c = 0; c < NUM_CH; c++) begin
            eligible[c]   = (state_q[c] == CH_RUN) && (rem_q[c] != '0) && !I_Abort[c];
            slot_keeps[c] = out_req_q && !I_Ack && (int'(out_ch_q) == c);
        end
    end

    // Search starts at rr_ptr, so the most recently served channel is tried last.
    always_comb begin
        grant_valid = 1'b0;
        grant       = '0;
        sel         = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            sel = WIDTH_CH'((int'(rr_ptr_q) + i) % NUM_CH);
            if (!grant_valid && eligible[sel]) begin
                grant_valid = 1'b1;
                grant       = sel;
            end
        end
    end

    always_comb begin
        done_d = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            state_d[c]  = state_q[c];
            addr_d[c]   = addr_q[c];
            stride_d[c] = stride_q[c];
            rem_d[c]    = rem_q[c];
            case (state_q[c])
                CH_IDLE: begin
                    if (I_Req[c] && !I_Abort[c]) begin
                        state_d[c]  = CH_RUN;
                        addr_d[c]   = I_Base[c*WIDTH_ADDR +: WIDTH_ADDR];
                        stride_d[c] = I_Stride[c*WIDTH_ADDR +: WIDTH_ADDR];
                        rem_d[c]    = I_Len[c*WIDTH_ADDR +: WIDTH_ADDR];
                    end
                end
                CH_RUN: begin
                    if (I_Abort[c]) begin
                        state_d[c] = slot_keeps[c] ? CH_DRAIN : CH_IDLE;
                    end else if (rem_q[c] == '0) begin
                        // All beats handed to the slot; finish once none of ours is left waiting.
                        if (!slot_keeps[c]) begin
                            state_d[c] = CH_IDLE;
                            done_d[c]  = 1'b1;
                        end
                    end else if (slot_free && grant_valid && int'(grant) == c) begin
                        addr_d[c] = addr_q[c] + stride_q[c];
                        rem_d[c]  = rem_q[c] - WIDTH_ADDR'(1);
                    end
                end
                CH_DRAIN: begin
                    if (!slot_keeps[c]) begin
                        state_d[c] = CH_IDLE;
                    end
                end
                default: begin
                    state_d[c] = CH_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        out_req_d  = out_req_q;
        out_addr_d = out_addr_q;
        out_ch_d   = out_ch_q;
        out_last_d = out_last_q;
        rr_ptr_d   = rr_ptr_q;
        if (slot_free) begin
            out_req_d  = grant_valid;
            out_last_d = 1'b0;
            if (grant_valid) begin
                out_addr_d = addr_q[grant];
                out_ch_d   = grant;
                out_last_d = (rem_q[grant] == WIDTH_ADDR'(1));
                rr_ptr_d   = (int'(grant) == NUM_CH - 1) ? '0 : grant + WIDTH_CH'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int c = 0; c < NUM_CH; c++) begin
                state_q[c]  <= CH_IDLE;
                addr_q[c]   <= '0;
                stride_q[c] <= '0;
                rem_q[c]    <= '0;
            end
            done_q     <= '0;
            rr_ptr_q   <= '0;
            out_req_q  <= 1'b0;
            out_addr_q <= '0;
            out_ch_q   <= '0;
            out_last_q <= 1'b0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                state_q[c]  <= state_d[c];
                addr_q[c]   <= addr_d[c];
                stride_q[c] <= stride_d[c];
                rem_q[c]    <= rem_d[c];
            end
            done_q     <= done_d;
            rr_ptr_q   <= rr_ptr_d;
            out_req_q  <= out_req_d;
            out_addr_q <= out_addr_d;
            out_ch_q   <= out_ch_d;
            out_last_q <= out_last_d;
        end
    end

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            O_Busy[c] = (state_q[c] != CH_IDLE);
        end
    end

    assign O_Req  = out_req_q;
    assign O_Addr = out_addr_q;
    assign O_Ch   = out_ch_q;
    assign O_Last = out_last_q;
    assign O_Done = done_q;

endmodule

// File: tb/tb_tpu_stride_agu.sv
// Scoreboard bench for tpu_stride_agu: directed descriptors push expected beats and done
// pulses into queues; a negedge monitor compares every presented beat and every done pulse.
module tb_tpu_stride_agu;

    localparam int NUM_CH     = 2;
    localparam int WIDTH_ADDR = 10;
    localparam int WIDTH_CH   = 1;

    logic                         clock = 1'b0;
    logic                         reset;
    logic [NUM_CH-1:0]            i_req;
    logic [NUM_CH*WIDTH_ADDR-1:0] i_base;
    logic [NUM_CH*WIDTH_ADDR-1:0] i_stride;
    logic [NUM_CH*WIDTH_ADDR-1:0] i_len;
    logic [NUM_CH-1:0]            i_abort;
    logic [NUM_CH-1:0]            o_busy;
    logic                         o_req;
    logic [WIDTH_ADDR-1:0]        o_addr;
    logic [WIDTH_CH-1:0]          o_ch;
    logic                         o_last;
    logic                         i_ack;
    logic [NUM_CH-1:0]            o_done;

    typedef struct {
        logic [WIDTH_ADDR-1:0] addr;
        int                    ch;
        bit                    last;
    } beat_t;

    typedef struct {
        int ch;
        int cyc;
    } done_t;

    beat_t beat_q[$];
    done_t done_q[$];
    int    checks   = 0;
    int    failures = 0;
    int    cyc      = 0;

    tpu_stride_agu #(
        .NUM_CH    (NUM_CH),
        .WIDTH_ADDR(WIDTH_ADDR)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .I_Req   (i_req),
        .I_Base  (i_base),
        .I_Stride(i_stride),
        .I_Len   (i_len),
        .I_Abort (i_abort),
        .O_Busy  (o_busy),
        .O_Req   (o_req),
        .O_Addr  (o_addr),
        .O_Ch    (o_ch),
        .O_Last  (o_last),
        .I_Ack   (i_ack),
        .O_Done  (o_done)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: done pulses are expected on exact cycles; beats are compared while presented
    // (including stall cycles) and retired on the handshake.
    always @(negedge clock) begin
        logic [NUM_CH-1:0] exp_done;
        beat_t head;
        if (reset) begin
            exp_done = '0;
            for (int i = done_q.size() - 1; i >= 0; i--) begin
                if (done_q[i].cyc == cyc) exp_done = exp_done | (NUM_CH'(1) << done_q[i].ch);
                if (done_q[i].cyc <= cyc) done_q.delete(i);
            end
            check_output("o_done", 32'(o_done), 32'(exp_done));
            if (o_req) begin
                if (beat_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_beat: got addr %0h ch %0d, required no beat (cycle %0d)",
                             o_addr, o_ch, cyc);
                end else begin
                    head = beat_q[0];
                    check_output("beat_addr", 32'(o_addr), 32'(head.addr));
                    check_output("beat_ch", 32'(o_ch), 32'(head.ch));
                    check_output("beat_last", 32'(o_last), 32'(head.last));
                    if (i_ack) void'(beat_q.pop_front());
                end
            end
        end
    end

    task automatic push_beat(input logic [WIDTH_ADDR-1:0] addr, input int ch, input bit last);
        beat_t b;
        b.addr = addr;
        b.ch   = ch;
        b.last = last;
        beat_q.push_back(b);
    endtask

    task automatic push_done(input int ch, input int at);
        done_t d;
        d.ch  = ch;
        d.cyc = at;
        done_q.push_back(d);
    endtask

    task automatic set_desc(input int ch, input logic [WIDTH_ADDR-1:0] base,
                            input logic [WIDTH_ADDR-1:0] stride, input logic [WIDTH_ADDR-1:0] len);
        i_base[ch*WIDTH_ADDR +: WIDTH_ADDR]   = base;
        i_stride[ch*WIDTH_ADDR +: WIDTH_ADDR] = stride;
        i_len[ch*WIDTH_ADDR +: WIDTH_ADDR]    = len;
    endtask

    task automatic apply_stimulus(input logic [NUM_CH-1:0] mask);
        i_req = mask;
        @(posedge clock); #1;
        i_req = '0;
    endtask

    task automatic goto_cycle(input int t);
        while (cyc < t) begin
            @(posedge clock); #1;
        end
    endtask

    task automatic check_reset_state(input string tag);
        check_output({tag, "_busy"}, 32'(o_busy), 32'h0);
        check_output({tag, "_req"}, 32'(o_req), 32'h0);
        check_output({tag, "_addr"}, 32'(o_addr), 32'h0);
        check_output({tag, "_ch"}, 32'(o_ch), 32'h0);
        check_output({tag, "_last"}, 32'(o_last), 32'h0);
        check_output({tag, "_done"}, 32'(o_done), 32'h0);
    endtask

    task automatic do_reset();
        i_req   = '0;
        i_abort = '0;
        i_ack   = 1'b0;
        reset   = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check_reset_state("reset");
        beat_q.delete();
        done_q.delete();
        reset = 1'b1;
        i_ack = 1'b1;
    endtask

    task automatic wait_idle(input string name);
        int budget = 60;
        while ((o_busy != '0 || beat_q.size() != 0 || done_q.size() != 0) && budget > 0) begin
            @(posedge clock); #1;
            budget--;
        end
        checks++;
        if (budget == 0) begin
            failures++;
            $display("[TB] FAIL %s_timeout: busy=%0h beats_left=%0d dones_left=%0d, required all idle",
                     name, o_busy, beat_q.size(), done_q.size());
        end
    endtask

    initial begin
        int n;
        reset    = 1'b0;
        i_req    = '0;
        i_abort  = '0;
        i_ack    = 1'b0;
        i_base   = '0;
        i_stride = '0;
        i_len    = '0;
        do_reset();

        // Test 1: back-to-back beats, done right after last handshake, request while busy ignored
        set_desc(0, 10'h010, 10'h004, 10'd4);
        n = cyc;
        push_beat(10'h010, 0, 1'b0);
        push_beat(10'h014, 0, 1'b0);
        push_beat(10'h018, 0, 1'b0);
        push_beat(10'h01C, 0, 1'b1);
        push_done(0, n + 6);
        apply_stimulus(2'b01);
        check_output("t1_busy_after_accept", 32'(o_busy), 32'h1);
        goto_cycle(n + 3);
        set_desc(0, 10'h300, 10'h001, 10'd2);
        apply_stimulus(2'b01);
        wait_idle("t1");

        // Test 2: upward wrap on ch0, negative stride on ch1
        set_desc(0, 10'h3FE, 10'h001, 10'd4);
        n = cyc;
        push_beat(10'h3FE, 0, 1'b0);
        push_beat(10'h3FF, 0, 1'b0);
        push_beat(10'h000, 0, 1'b0);
        push_beat(10'h001, 0, 1'b1);
        push_done(0, n + 6);
        apply_stimulus(2'b01);
        wait_idle("t2a");
        set_desc(1, 10'h005, 10'h3FF, 10'd3);
        n = cyc;
        push_beat(10'h005, 1, 1'b0);
        push_beat(10'h004, 1, 1'b0);
        push_beat(10'h003, 1, 1'b1);
        push_done(1, n + 5);
        apply_stimulus(2'b10);
        check_output("t2_busy_ch1", 32'(o_busy), 32'h2);
        wait_idle("t2b");

        // Test 3: two channels started together interleave round-robin from ch0
        do_reset();
        set_desc(0, 10'h100, 10'h001, 10'd3);
        set_desc(1, 10'h200, 10'h002, 10'd3);
        n = cyc;
        push_beat(10'h100, 0, 1'b0);
        push_beat(10'h200, 1, 1'b0);
        push_beat(10'h101, 0, 1'b0);
        push_beat(10'h202, 1, 1'b0);
        push_beat(10'h102, 0, 1'b1);
        push_beat(10'h204, 1, 1'b1);
        push_done(0, n + 7);
        push_done(1, n + 8);
        apply_stimulus(2'b11);
        check_output("t3_busy_both", 32'(o_busy), 32'h3);
        wait_idle("t3");

        // Test 4: three-cycle stall on the second beat
        set_desc(0, 10'h080, 10'h008, 10'd4);
        n = cyc;
        push_beat(10'h080, 0, 1'b0);
        push_beat(10'h088, 0, 1'b0);
        push_beat(10'h090, 0, 1'b0);
        push_beat(10'h098, 0, 1'b1);
        push_done(0, n + 9);
        apply_stimulus(2'b01);
        goto_cycle(n + 3);
        i_ack = 1'b0;
        goto_cycle(n + 6);
        i_ack = 1'b1;
        wait_idle("t4");

        // Test 5: abort with the third beat stalled in the slot
        set_desc(0, 10'h040, 10'h003, 10'd8);
        n = cyc;
        push_beat(10'h040, 0, 1'b0);
        push_beat(10'h043, 0, 1'b0);
        push_beat(10'h046, 0, 1'b0);
        apply_stimulus(2'b01);
        goto_cycle(n + 4);
        i_ack      = 1'b0;
        i_abort[0] = 1'b1;
        goto_cycle(n + 5);
        i_abort[0] = 1'b0;
        check_output("t5_busy_draining", 32'(o_busy), 32'h1);
        goto_cycle(n + 6);
        check_output("t5_busy_still", 32'(o_busy), 32'h1);
        i_ack = 1'b1;
        goto_cycle(n + 7);
        check_output("t5_busy_after_ack", 32'(o_busy), 32'h0);
        check_output("t5_req_after_ack", 32'(o_req), 32'h0);
        goto_cycle(n + 11);
        check_output("t5_no_more_beats", 32'(o_req), 32'h0);
        wait_idle("t5");

        // Test 5b: reset while a beat is stalled discards everything
        set_desc(0, 10'h200, 10'h001, 10'd8);
        i_ack = 1'b0;
        n = cyc;
        push_beat(10'h200, 0, 1'b0);
        apply_stimulus(2'b01);
        goto_cycle(n + 3);
        reset = 1'b0;
        goto_cycle(n + 4);
        check_reset_state("midreset");
        beat_q.delete();
        done_q.delete();
        reset = 1'b1;
        i_ack = 1'b1;

        // Abort and request together on an idle channel: descriptor dropped
        set_desc(1, 10'h0AA, 10'h001, 10'd2);
        i_abort[1] = 1'b1;
        apply_stimulus(2'b10);
        i_abort[1] = 1'b0;
        check_output("abort_req_busy", 32'(o_busy), 32'h0);
        @(posedge clock); #1;
        check_output("abort_req_noreq", 32'(o_req), 32'h0);

        // Test 6: zero-length descriptor
        set_desc(1, 10'h123, 10'h001, 10'd0);
        n = cyc;
        push_done(1, n + 2);
        apply_stimulus(2'b10);
        check_output("t6_busy", 32'(o_busy), 32'h2);
        goto_cycle(n + 2);
        check_output("t6_busy_clear", 32'(o_busy), 32'h0);
        check_output("t6_no_req", 32'(o_req), 32'h0);
        wait_idle("t6");

        repeat (3) @(posedge clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
